uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receiver's character output and the APB register block's RBR read path.
- Stores each received character with its frame-error and parity-error status, and provides show-ahead read data.
- Tracks overrun and raises a trigger-level interrupt request for the UART interrupt-ID logic.

Parameters:
DEPTH, 16, number of entries; power of 2, minimum 4
DATA_W, 8, character width in bits
TOUT_TICKS, 640, receive_clk_en pulses of idle before timeout (4 chars x 10 bits x 16 oversample); used only with the optional feature

Ports:
sys_clk  in  1  system clock, rising edge
rst_b  in  1  asynchronous active-low reset
receive_fifo_wr_vld  in  1  single-cycle pulse: receiver has completed a character
receive_fifo_wdata  in  DATA_W  received character
receive_fifo_fe  in  1  frame error for this character
receive_fifo_pe  in  1  parity error for this character
reg_fifo_rd  in  1  single-cycle pop: RBR read
reg_fifo_lsr_read  in  1  LSR read pulse; clears sticky overrun
reg_fifo_clr  in  1  flush pulse (FCR receive-reset)
reg_fifo_trig_lvl  in  2  trigger level select
receive_clk_en  in  1  oversample tick; used only with the optional feature
fifo_reg_rdata  out  DATA_W  head character (show-ahead)
fifo_reg_fe  out  1  head entry frame error
fifo_reg_pe  out  1  head entry parity error
fifo_reg_rbr_vld  out  1  FIFO not empty
fifo_reg_oe  out  1  sticky overrun
fifo_reg_count  out  log2(DEPTH)+1  occupancy
fifo_ctrl_trig_int  out  1  occupancy >= trigger level
fifo_ctrl_tout_int  out  1  character timeout; tied 0 when the optional feature is absent

Behaviour:
- Clock and reset: one clock, sys_clk. Reset rst_b is asynchronous, active-low.
- Reset values:
  - All outputs are 0.
  - Pointers, count, overrun and timeout counter are 0.
  - Memory contents are not reset.
- Storage:
  - DEPTH x (DATA_W+2) array holding {pe, fe, data}.
  - Read and write pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty: pointers equal. Full: low bits equal and MSBs differ.
- Push: wr_vld & !full writes at wptr; wptr increments in the same edge.
  - Data is visible on rdata the next cycle if the FIFO was empty.
- Pop: rd & !empty increments rptr.
  - rdata, fe and pe are driven combinationally from mem[rptr]; zero added read latency.
  - Pop while empty is ignored; no underflow flag.
- Push while full: character is dropped; oe is set on the next edge. Memory and pointers are unchanged.
- Simultaneous push and pop:
  - Full: pop occurs, push is accepted, count unchanged, oe not set.
  - Empty: push accepted, pop ignored.
- oe:
  - Set on a dropped push; cleared by reg_fifo_lsr_read.
  - Set and clear in the same cycle: set wins.
- reg_fifo_clr:
  - Highest priority: pointers and count go to 0 next edge; push and pop in that cycle are discarded.
  - oe is unaffected.
- count = wptr - rptr, modulo 2^(log2(DEPTH)+1); registered with the pointers.
- Trigger level:
  - 00 -> 1, 01 -> DEPTH/4, 10 -> DEPTH/2, 11 -> DEPTH-2.
  - trig_int = (count >= level), combinational from registered count, so it asserts 1 cycle after the threshold-crossing push.
  - trig_lvl may change at any time; trig_int follows immediately.

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN
- Defined:
  - A 10-bit counter increments on receive_clk_en while FIFO is non-empty.
  - It resets to 0 on any accepted push, accepted pop, clr, or when empty.
  - At TOUT_TICKS it saturates and tout_int=1.
  - tout_int stays high until the next accepted pop, push, or clr.
- Undefined: no counter; fifo_ctrl_tout_int tied 0; receive_clk_en unused.

Decomposition:
- Shared package uart_pkg:
  - trigger-level encodings
  - FIFO entry width constant (DATA_W+2)
  - default TOUT_TICKS
- Sub-module uart_rx_fifo_mem: plain register array with synchronous write and asynchronous read, reusable for a later TX FIFO.
- Pointer, flag and interrupt logic stays in uart_rx_fifo.

Test Plan:
1. Reset mid-fill: 5 pushes then rst_b low -> count=0, rbr_vld=0, oe=0 asynchronously.
2. Push 0x41, 0x42, 0x43 (fe=1 on 0x42); pop 3 times -> rdata 0x41/0x42/0x43 with fe 0/1/0; rbr_vld falls after the 3rd pop.
3. Fill 16, push 0x55 -> oe=1, count=16, head still first char. LSR read -> oe=0. Push+pop at full -> count stays 16, oe stays 0.
4. trig_lvl=10, push 7 -> trig_int=0. 8th push -> trig_int=1 next cycle. Switch to 11 -> trig_int=0 until count=14.
5. clr concurrent with push and pop at count=6 -> count=0 next cycle; oe preserved if previously set.
6. With UART_RX_FIFO_TIMEOUT_EN: push 1 char, then 640 receive_clk_en ticks idle -> tout_int=1 on tick 640. Pop -> tout_int=0. Without the macro -> tout_int remains 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: trigger-level encodings, FIFO entry sizing and
// default character-timeout length.
package uart_pkg;

  localparam int unsigned STATUS_W           = 2;
  localparam int unsigned TOUT_TICKS_DEFAULT = 640;

  typedef enum logic [1:0] {
    TRIG_ONE       = 2'b00,
    TRIG_QUARTER   = 2'b01,
    TRIG_HALF      = 2'b10,
    TRIG_NEAR_FULL = 2'b11
  } trig_lvl_e;

  // Stored entry is {pe, fe, data}.
  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + STATUS_W;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Plain register array: synchronous write, asynchronous read. Contents are
// not reset.
module uart_rx_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with show-ahead read, sticky overrun and trigger-level
// interrupt. Define UART_RX_FIFO_TIMEOUT_EN to add the character timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TOUT_TICKS = TOUT_TICKS_DEFAULT
) (
  input  logic                       sys_clk,
  input  logic                       rst_b,
  input  logic                       receive_fifo_wr_vld,
  input  logic [DATA_W-1:0]          receive_fifo_wdata,
  input  logic                       receive_fifo_fe,
  input  logic                       receive_fifo_pe,
  input  logic                       reg_fifo_rd,
  input  logic                       reg_fifo_lsr_read,
  input  logic                       reg_fifo_clr,
  input  logic [1:0]                 reg_fifo_trig_lvl,
  input  logic                       receive_clk_en,
  output logic [DATA_W-1:0]          fifo_reg_rdata,
  output logic                       fifo_reg_fe,
  output logic                       fifo_reg_pe,
  output logic                       fifo_reg_rbr_vld,
  output logic                       fifo_reg_oe,
  output logic [$clog2(DEPTH):0]     fifo_reg_count,
  output logic                       fifo_ctrl_trig_int,
  output logic                       fifo_ctrl_tout_int
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = entry_w(DATA_W);

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic          oe_q, oe_d;
  logic          empty, full, push_ok, pop_ok, drop;
  logic [EW-1:0] wr_entry, rd_entry;
  logic [PW-1:0] trig_level;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop_ok  = reg_fifo_rd && !empty && !reg_fifo_clr;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push_ok = receive_fifo_wr_vld && (!full || reg_fifo_rd) && !reg_fifo_clr;
  assign drop    = receive_fifo_wr_vld && full && !reg_fifo_rd && !reg_fifo_clr;

  assign wr_entry = {receive_fifo_pe, receive_fifo_fe, receive_fifo_wdata};

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (sys_clk),
    .wr_en (push_ok),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    oe_d   = oe_q;
    if (reg_fifo_clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop_ok)  rptr_d = rptr_q + PW'(1);
    end
    if (drop)                   oe_d = 1'b1;
    else if (reg_fifo_lsr_read) oe_d = 1'b0;
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    trig_level = PW'(1);
    case (trig_lvl_e'(reg_fifo_trig_lvl))
      TRIG_ONE:       trig_level = PW'(1);
      TRIG_QUARTER:   trig_level = PW'(DEPTH / 4);
      TRIG_HALF:      trig_level = PW'(DEPTH / 2);
      TRIG_NEAR_FULL: trig_level = PW'(DEPTH - 2);
    endcase
  end

  // Head is forced to zero when empty so stale memory never leaks out.
  assign {fifo_reg_pe, fifo_reg_fe, fifo_reg_rdata} = empty ? '0 : rd_entry;
  assign fifo_reg_rbr_vld   = !empty;
  assign fifo_reg_oe        = oe_q;
  assign fifo_reg_count     = count_q;
  assign fifo_ctrl_trig_int = (count_q >= trig_level);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TW = 10;

  logic [TW-1:0] tout_cnt_q, tout_cnt_d;

  // Idle counter, saturating at the timeout length.
  always_comb begin
    tout_cnt_d = tout_cnt_q;
    if (reg_fifo_clr || push_ok || pop_ok || empty) begin
      tout_cnt_d = '0;
    end else if (receive_clk_en && (tout_cnt_q != TW'(TOUT_TICKS))) begin
      tout_cnt_d = tout_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) tout_cnt_q <= '0;
    else        tout_cnt_q <= tout_cnt_d;
  end

  assign fifo_ctrl_tout_int = (tout_cnt_q == TW'(TOUT_TICKS));
`else
  logic unused_tout;
  assign unused_tout        = receive_clk_en ^ (TOUT_TICKS == 0);
  assign fifo_ctrl_tout_int = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (default DEPTH=16, DATA_W=8).
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TOUT  = 640;

  logic       sys_clk = 1'b0;
  logic       rst_b   = 1'b0;
  logic       wr_vld  = 1'b0;
  logic [7:0] wdata   = '0;
  logic       fe_i    = 1'b0;
  logic       pe_i    = 1'b0;
  logic       rd      = 1'b0;
  logic       lsr     = 1'b0;
  logic       clr     = 1'b0;
  logic [1:0] trig    = 2'b00;
  logic       clk_en  = 1'b0;
  logic [7:0] rdata;
  logic       fe_o, pe_o, rbr_vld, oe, trig_int, tout_int;
  logic [4:0] count;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [7:0] d;
  } ent_t;

  ent_t sb[$];
  logic model_oe = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   levels [4] = '{1, 4, 8, 14};

  uart_rx_fifo dut (
    .sys_clk             (sys_clk),
    .rst_b               (rst_b),
    .receive_fifo_wr_vld (wr_vld),
    .receive_fifo_wdata  (wdata),
    .receive_fifo_fe     (fe_i),
    .receive_fifo_pe     (pe_i),
    .reg_fifo_rd         (rd),
    .reg_fifo_lsr_read   (lsr),
    .reg_fifo_clr        (clr),
    .reg_fifo_trig_lvl   (trig),
    .receive_clk_en      (clk_en),
    .fifo_reg_rdata      (rdata),
    .fifo_reg_fe         (fe_o),
    .fifo_reg_pe         (pe_o),
    .fifo_reg_rbr_vld    (rbr_vld),
    .fifo_reg_oe         (oe),
    .fifo_reg_count      (count),
    .fifo_ctrl_trig_int  (trig_int),
    .fifo_ctrl_tout_int  (tout_int)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d, input logic fe, input logic pe);
    wr_vld = 1'b1; wdata = d; fe_i = fe; pe_i = pe;
    tick;
    wr_vld = 1'b0; fe_i = 1'b0; pe_i = 1'b0;
    if (sb.size() < DEPTH) sb.push_back(ent_t'({pe, fe, d}));
    else                   model_oe = 1'b1;
  endtask

  task automatic do_pop(input string name);
    ent_t exp;
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      n_checks++;
      if ({pe_o, fe_o, rdata} !== exp) begin
        n_fail++;
        $display("FAIL %s: head {pe,fe,data} got %h expected %h", name, {pe_o, fe_o, rdata}, exp);
      end
    end
    rd = 1'b1;
    tick;
    rd = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({count, rbr_vld, oe, trig_int, tout_int, rdata, fe_o, pe_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected 0", {count, rbr_vld, oe, trig_int, tout_int, rdata, fe_o, pe_o});
    end
    tick; tick;
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) do_push(8'(8'h10 + i), 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd5) begin
      n_fail++; $display("FAIL fill_before_reset: count got %0d expected 5", count);
    end
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if ({count, rbr_vld, oe} !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset: count/rbr_vld/oe got %0d/%b/%b expected 0/0/0", count, rbr_vld, oe);
    end
    sb.delete();
    model_oe = 1'b0;
    tick;
    rst_b = 1'b1;
    tick;
  endtask

  task automatic test_order;
    do_push(8'h41, 1'b0, 1'b0);
    n_checks++;
    if (rbr_vld !== 1'b1 || rdata !== 8'h41) begin
      n_fail++; $display("FAIL show_ahead: rbr_vld/rdata got %b/%h expected 1/41", rbr_vld, rdata);
    end
    do_push(8'h42, 1'b1, 1'b0);
    do_push(8'h43, 1'b0, 1'b1);
    do_pop("order_0");
    do_pop("order_1");
    n_checks++;
    if (rbr_vld !== 1'b1) begin
      n_fail++; $display("FAIL rbr_vld_before_last: got %b expected 1", rbr_vld);
    end
    do_pop("order_2");
    n_checks++;
    if (rbr_vld !== 1'b0 || count !== 5'd0) begin
      n_fail++; $display("FAIL drained: rbr_vld/count got %b/%0d expected 0/0", rbr_vld, count);
    end
    do_pop("pop_empty");
    n_checks++;
    if (count !== 5'd0 || rbr_vld !== 1'b0) begin
      n_fail++; $display("FAIL underflow_ignored: count got %0d expected 0", count);
    end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < DEPTH; i++) do_push(8'(i * 3), 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd16 || oe !== 1'b0) begin
      n_fail++; $display("FAIL full: count/oe got %0d/%b expected 16/0", count, oe);
    end
    do_push(8'h55, 1'b0, 1'b0);
    n_checks++;
    if (oe !== model_oe || count !== 5'(sb.size()) || rdata !== sb[0].d) begin
      n_fail++;
      $display("FAIL overrun: oe/count/head got %b/%0d/%h expected %b/%0d/%h", oe, count, rdata, model_oe, sb.size(), sb[0].d);
    end
    lsr = 1'b1; tick; lsr = 1'b0;
    model_oe = 1'b0;
    n_checks++;
    if (oe !== 1'b0) begin
      n_fail++; $display("FAIL lsr_clear: oe got %b expected 0", oe);
    end
    // push and pop together at full
    n_checks++;
    if (rdata !== sb[0].d) begin
      n_fail++; $display("FAIL head_at_full: got %h expected %h", rdata, sb[0].d);
    end
    void'(sb.pop_front());
    sb.push_back(ent_t'({1'b1, 1'b0, 8'hAA}));
    wr_vld = 1'b1; wdata = 8'hAA; pe_i = 1'b1; rd = 1'b1;
    tick;
    wr_vld = 1'b0; pe_i = 1'b0; rd = 1'b0;
    n_checks++;
    if (count !== 5'd16 || oe !== 1'b0) begin
      n_fail++; $display("FAIL push_pop_full: count/oe got %0d/%b expected 16/0", count, oe);
    end
    // drop and LSR read in the same cycle: set wins
    wr_vld = 1'b1; wdata = 8'h66; lsr = 1'b1;
    tick;
    wr_vld = 1'b0; lsr = 1'b0;
    model_oe = 1'b1;
    n_checks++;
    if (oe !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL set_beats_clear: oe/count got %b/%0d expected 1/16", oe, count);
    end
    while (sb.size() != 0) do_pop("drain_full");
    n_checks++;
    if (rbr_vld !== 1'b0 || oe !== 1'b1) begin
      n_fail++; $display("FAIL after_drain: rbr_vld/oe got %b/%b expected 0/1", rbr_vld, oe);
    end
    lsr = 1'b1; tick; lsr = 1'b0;
    model_oe = 1'b0;
  endtask

  task automatic test_trigger;
    trig = 2'b10;
    for (int i = 0; i < 7; i++) do_push(8'(8'h80 + i), 1'b0, 1'b0);
    n_checks++;
    if (trig_int !== 1'b0) begin
      n_fail++; $display("FAIL trig_half_7: got %b expected 0", trig_int);
    end
    do_push(8'h87, 1'b0, 1'b0);
    n_checks++;
    if (trig_int !== 1'b1) begin
      n_fail++; $display("FAIL trig_half_8: got %b expected 1", trig_int);
    end
    trig = 2'b11;
    #1;
    n_checks++;
    if (trig_int !== 1'b0) begin
      n_fail++; $display("FAIL trig_switch: got %b expected 0", trig_int);
    end
    while (sb.size() < 14) begin
      n_checks++;
      if (trig_int !== (sb.size() >= levels[3])) begin
        n_fail++; $display("FAIL trig_near_full: count %0d got %b expected 0", sb.size(), trig_int);
      end
      do_push(8'(sb.size()), 1'b0, 1'b0);
    end
    n_checks++;
    if (trig_int !== 1'b1) begin
      n_fail++; $display("FAIL trig_near_full_14: got %b expected 1", trig_int);
    end
    for (int l = 0; l < 4; l++) begin
      while (sb.size() > 2 + l) do_pop("trig_drain");
      for (int t = 0; t < 4; t++) begin
        trig = 2'(t);
        #1;
        n_checks++;
        if (trig_int !== (sb.size() >= levels[t])) begin
          n_fail++;
          $display("FAIL trig_sweep: lvl %0d count %0d got %b expected %b", t, sb.size(), trig_int, sb.size() >= levels[t]);
        end
      end
    end
    trig = 2'b00;
  endtask

  task automatic test_clr;
    while (sb.size() < DEPTH) do_push(8'(8'hC0 + sb.size()), 1'b0, 1'b0);
    do_push(8'hEE, 1'b0, 1'b0);
    while (sb.size() > 6) do_pop("clr_setup");
    n_checks++;
    if (count !== 5'd6 || oe !== 1'b1) begin
      n_fail++; $display("FAIL clr_setup: count/oe got %0d/%b expected 6/1", count, oe);
    end
    clr = 1'b1; wr_vld = 1'b1; wdata = 8'h99; rd = 1'b1;
    tick;
    clr = 1'b0; wr_vld = 1'b0; rd = 1'b0;
    sb.delete();
    n_checks++;
    if (count !== 5'd0 || rbr_vld !== 1'b0 || oe !== 1'b1 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL clr: count/rbr_vld/oe/rdata got %0d/%b/%b/%h expected 0/0/1/00", count, rbr_vld, oe, rdata);
    end
    lsr = 1'b1; tick; lsr = 1'b0;
    model_oe = 1'b0;
    do_push(8'h3C, 1'b1, 1'b1);
    do_pop("after_clr");
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 400; c++) begin
      logic w, r;
      ent_t e;
      w = 1'($urandom_range(0, 99) < 55);
      r = 1'($urandom_range(0, 99) < 45);
      e = ent_t'($urandom);
      if (r && sb.size() != 0) begin
        n_checks++;
        if ({pe_o, fe_o, rdata} !== sb[0]) begin
          n_fail++; $display("FAIL b2b_head: cycle %0d got %h expected %h", c, {pe_o, fe_o, rdata}, sb[0]);
        end
        void'(sb.pop_front());
        if (w) sb.push_back(e);
      end else if (w) begin
        if (sb.size() < DEPTH) sb.push_back(e);
        else                   model_oe = 1'b1;
      end
      wr_vld = w; rd = r; {pe_i, fe_i, wdata} = e;
      tick;
      wr_vld = 1'b0; rd = 1'b0;
      n_checks++;
      if (count !== 5'(sb.size()) || rbr_vld !== (sb.size() != 0) || oe !== model_oe) begin
        n_fail++;
        $display("FAIL b2b_state: cycle %0d count/rbr_vld/oe got %0d/%b/%b expected %0d/%b/%b",
                 c, count, rbr_vld, oe, sb.size(), sb.size() != 0, model_oe);
      end
    end
    clr = 1'b1; lsr = 1'b1; tick; clr = 1'b0; lsr = 1'b0;
    sb.delete();
    model_oe = 1'b0;
  endtask

  task automatic test_timeout;
    do_push(8'h7E, 1'b0, 1'b0);
    clk_en = 1'b1;
    for (int t = 1; t <= TOUT + 20; t++) begin
      tick;
`ifdef UART_RX_FIFO_TIMEOUT_EN
      if (t == TOUT - 1 || t == TOUT || t == TOUT + 20) begin
        n_checks++;
        if (tout_int !== (t >= TOUT)) begin
          n_fail++; $display("FAIL tout_tick: tick %0d got %b expected %b", t, tout_int, t >= TOUT);
        end
      end
`else
      if (t == TOUT || t == TOUT + 20) begin
        n_checks++;
        if (tout_int !== 1'b0) begin
          n_fail++; $display("FAIL tout_absent: tick %0d got %b expected 0", t, tout_int);
        end
      end
`endif
    end
    clk_en = 1'b0;
    do_pop("tout_pop");
    n_checks++;
    if (tout_int !== 1'b0 || rbr_vld !== 1'b0) begin
      n_fail++; $display("FAIL tout_clear: tout/rbr_vld got %b/%b expected 0/0", tout_int, rbr_vld);
    end
  endtask

  initial begin
    test_reset;
    test_order;
    test_overrun;
    test_trigger;
    test_clr;
    test_back_to_back;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
